sram_confreg: RTL and testbench
===============================

# sram_confreg

Uncached peripheral register block that answers CPU data-SRAM-port transactions in the physical confreg window. It is the responder to the core's data SRAM interface (en/wen/addr/wdata in, rdata out one cycle later). It holds board I/O registers (LEDs, tri-colour LEDs, seven-segment value and switch readback), a free-running 32-bit timer, and a compare interrupt that feeds the core's ext_int. The address decoder upstream asserts data_sram_en to this block only for the confreg window; the block decodes only the low 16 address bits.

## Interface
- SW_W, 8: width of the switch input.
- LED_W, 16: width of the LED output.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data_sram_en  in  1  transaction request this cycle.
- data_sram_wen  in  4  byte write enables; 0 means read, bit i enables wdata[8i+7:8i].
- data_sram_addr  in  32  byte address; only [15:0] decoded, [1:0] ignored.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data, registered.
- switch  in  SW_W  raw asynchronous switch levels.
- led  out  LED_W  LED register.
- led_rg0, led_rg1  out  2 each  tri-colour LED registers.
- num_data  out  32  seven-segment value register.
- timer_int  out  1  level interrupt to the core (routes to ext_int[5]).

## Operation
Register map (offset = addr[15:0]):
- 0xF000 LED, RW, low LED_W bits.
- 0xF004 LED_RG0, RW, bits [1:0].
- 0xF008 LED_RG1, RW, bits [1:0].
- 0xF010 NUM, RW, 32 bits.
- 0xF020 SWITCH, RO, zero-extended synchronized switch value.
- 0xE000 TIMER, RW, 32 bits.
- 0xE004 TIMER_CMP, RW, 32 bits.
- 0xE008 TIMER_CTRL, RW: bit0 cmp_en, bit1 irq_pending (write 1 to clear).
- 0xFFF0 SCRATCH, RW, 32 bits.

Access rules:
- Reads of unmapped offsets return 0. Writes to unmapped offsets and to SWITCH are ignored.
- Writes are byte-merged: each enabled lane replaces that byte, other lanes keep their old bytes. Unimplemented bits read 0 and ignore writes.

Timer:
- TIMER increments by 1 every cycle and wraps 0xFFFFFFFF to 0.
- On a TIMER write cycle, the next value is the byte-merged write value, with no increment that cycle.

Compare:
- irq_pending is set when cmp_en=1 and the next-cycle TIMER value equals TIMER_CMP.
- irq_pending is sticky. Writing TIMER_CTRL with lane 0 enabled and wdata[1]=1 clears it.
- If a set and a clear happen in the same cycle, set wins.
- timer_int = irq_pending, registered output.

Switch input: synchronized through two flops. SWITCH reads return the second-flop value.

## Timing
Reset (resetn low, asynchronous) clears all outputs and registers to 0:
- data_sram_rdata, led, led_rg0, led_rg1, num_data, TIMER, TIMER_CMP, cmp_en, irq_pending, SCRATCH and the synchronizer flops.
- timer_int=0.
- The first increment happens on the first rising edge after resetn rises.

Read latency:
- data_sram_rdata is captured at the edge where data_sram_en=1 and data_sram_wen=0, so it is valid during the following cycle.
- rdata holds until the next read. Write cycles and idle cycles do not change rdata.
- A TIMER read returns the value TIMER held during the request cycle, before that edge's increment.

Write latency: a register updates at the edge ending the request cycle. A read issued the next cycle returns the new value. There is no back-pressure: one transaction is accepted every cycle.

Switch latency: a switch change is visible to a read issued at least 2 cycles later.

Interrupt: the compare match and timer_int rise at the same edge. The clear takes effect at the edge ending the clearing write.

## Test plan
- Reset then read 0xF000, 0xE004, 0xFFF0, 0x1234 → rdata=0 the cycle after each read; timer_int=0.
- Write 0xF010 with wdata=0xAABBCCDD, wen=0xF, then wen=0x2 with wdata=0x00001100, then read → 0xAABB11DD; num_data matches.
- Write TIMER=0xFFFFFFFE, then read on the two following cycles → 0xFFFFFFFE then 0xFFFFFFFF; the next read returns 0 (wrap).
- TIMER_CMP=0x20, TIMER_CTRL=1, TIMER=0x10 → timer_int rises exactly 16 cycles after the TIMER write edge and stays high.
- Write TIMER_CTRL=0x3 (W1C) → timer_int falls next edge. Repeat with the clear coinciding with a match → timer_int stays 1.
- switch=0x5A → a read 1 cycle later returns the old value; a read 2+ cycles later returns 0x5A. A write to 0xF020 does not change the read value.

Source files
------------

// File: rtl/sram_confreg.sv
// Confreg window responder for the CPU data SRAM port: board I/O registers,
// a free-running timer with compare interrupt, and a scratch register.
module sram_confreg #(
    parameter int SW_W  = 8,
    parameter int LED_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic [1:0]        led_rg0,
    output logic [1:0]        led_rg1,
    output logic [31:0]       num_data,
    output logic              timer_int
);

    localparam logic [15:0] OFF_LED      = 16'hF000;
    localparam logic [15:0] OFF_LED_RG0  = 16'hF004;
    localparam logic [15:0] OFF_LED_RG1  = 16'hF008;
    localparam logic [15:0] OFF_NUM      = 16'hF010;
    localparam logic [15:0] OFF_SWITCH   = 16'hF020;
    localparam logic [15:0] OFF_TIMER    = 16'hE000;
    localparam logic [15:0] OFF_TIMER_CMP = 16'hE004;
    localparam logic [15:0] OFF_TIMER_CTRL = 16'hE008;
    localparam logic [15:0] OFF_SCRATCH  = 16'hFFF0;

    logic [31:0]      timer_q;
    logic [31:0]      timer_cmp_q;
    logic             cmp_en_q;
    logic             irq_pending_q;
    logic [31:0]      scratch_q;
    logic [SW_W-1:0]  sw_meta_q;
    logic [SW_W-1:0]  sw_sync_q;

    logic [15:0]      off;
    logic             wr;
    logic             rd;
    logic [31:0]      rd_val;
    logic [31:0]      led_wval;
    logic [31:0]      timer_next;
    logic             irq_set;
    logic             irq_clr;
    logic             unused_addr_bits;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign off              = {data_sram_addr[15:2], 2'b00};
    assign unused_addr_bits = ^{data_sram_addr[31:16], data_sram_addr[1:0]};
    assign wr               = data_sram_en && (data_sram_wen != 4'b0000);
    assign rd               = data_sram_en && (data_sram_wen == 4'b0000);
    assign timer_int        = irq_pending_q;

    always_comb begin
        rd_val = 32'h0;
        case (off)
            OFF_LED:        rd_val = 32'(led);
            OFF_LED_RG0:    rd_val = {30'h0, led_rg0};
            OFF_LED_RG1:    rd_val = {30'h0, led_rg1};
            OFF_NUM:        rd_val = num_data;
            OFF_SWITCH:     rd_val = 32'(sw_sync_q);
            OFF_TIMER:      rd_val = timer_q;
            OFF_TIMER_CMP:  rd_val = timer_cmp_q;
            OFF_TIMER_CTRL: rd_val = {30'h0, irq_pending_q, cmp_en_q};
            OFF_SCRATCH:    rd_val = scratch_q;
            default:        rd_val = 32'h0;
        endcase
    end

    // Compare looks at the value TIMER will hold after this edge, so the
    // match and timer_int rise together.
    always_comb begin
        led_wval   = byte_merge(32'(led), data_sram_wdata, data_sram_wen);
        timer_next = (wr && off == OFF_TIMER)
                   ? byte_merge(timer_q, data_sram_wdata, data_sram_wen)
                   : timer_q + 32'd1;
        irq_set    = cmp_en_q && (timer_next == timer_cmp_q);
        irq_clr    = wr && (off == OFF_TIMER_CTRL) && data_sram_wen[0]
                     && data_sram_wdata[1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= 32'h0;
            led             <= '0;
            led_rg0         <= 2'b00;
            led_rg1         <= 2'b00;
            num_data        <= 32'h0;
            timer_q         <= 32'h0;
            timer_cmp_q     <= 32'h0;
            cmp_en_q        <= 1'b0;
            irq_pending_q   <= 1'b0;
            scratch_q       <= 32'h0;
            sw_meta_q       <= '0;
            sw_sync_q       <= '0;
        end else begin
            sw_meta_q     <= switch;
            sw_sync_q     <= sw_meta_q;
            timer_q       <= timer_next;
            irq_pending_q <= irq_set || (irq_pending_q && !irq_clr);
            if (rd) data_sram_rdata <= rd_val;
            if (wr) begin
                case (off)
                    OFF_LED:       led <= led_wval[LED_W-1:0];
                    OFF_LED_RG0:   if (data_sram_wen[0]) led_rg0 <= data_sram_wdata[1:0];
                    OFF_LED_RG1:   if (data_sram_wen[0]) led_rg1 <= data_sram_wdata[1:0];
                    OFF_NUM:       num_data <= byte_merge(num_data, data_sram_wdata, data_sram_wen);
                    OFF_TIMER_CMP: timer_cmp_q <= byte_merge(timer_cmp_q, data_sram_wdata, data_sram_wen);
                    OFF_TIMER_CTRL: if (data_sram_wen[0]) cmp_en_q <= data_sram_wdata[0];
                    OFF_SCRATCH:   scratch_q <= byte_merge(scratch_q, data_sram_wdata, data_sram_wen);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_confreg.sv
// Self-checking bench for sram_confreg: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the register map.
module tb_sram_confreg;
    localparam int SW_W  = 8;
    localparam int LED_W = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              data_sram_en;
    logic [3:0]        data_sram_wen;
    logic [31:0]       data_sram_addr;
    logic [31:0]       data_sram_wdata;
    logic [31:0]       data_sram_rdata;
    logic [SW_W-1:0]   switch;
    logic [LED_W-1:0]  led;
    logic [1:0]        led_rg0;
    logic [1:0]        led_rg1;
    logic [31:0]       num_data;
    logic              timer_int;

    int checks = 0;
    int errors = 0;

    logic [SW_W-1:0] sw_drv = '0;

    // behavioural model state
    logic [31:0]     m_rdata = 0;
    logic [15:0]     m_led = 0;
    logic [1:0]      m_rg0 = 0;
    logic [1:0]      m_rg1 = 0;
    logic [31:0]     m_num = 0;
    logic [31:0]     m_timer = 0;
    logic [31:0]     m_cmp = 0;
    logic            m_cmp_en = 0;
    logic            m_irq = 0;
    logic [31:0]     m_scratch = 0;
    logic [SW_W-1:0] m_sw_prev1 = 0;  // switch level at the previous edge
    logic [SW_W-1:0] m_sw_prev2 = 0;  // switch level two edges ago

    always #5 clk = ~clk;

    sram_confreg #(.SW_W(SW_W), .LED_W(LED_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch          (switch),
        .led             (led),
        .led_rg0         (led_rg0),
        .led_rg1         (led_rg1),
        .num_data        (num_data),
        .timer_int       (timer_int)
    );

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] o);
        case (o)
            16'hF000: return {16'h0, m_led};
            16'hF004: return {30'h0, m_rg0};
            16'hF008: return {30'h0, m_rg1};
            16'hF010: return m_num;
            16'hF020: return {24'h0, m_sw_prev2};
            16'hE000: return m_timer;
            16'hE004: return m_cmp;
            16'hE008: return {30'h0, m_irq, m_cmp_en};
            16'hFFF0: return m_scratch;
            default:  return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, advance the model by one edge, sample 1 time unit after the edge.
    task automatic txn(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wd);
        logic [15:0] o;
        logic        w;
        logic [31:0] tn;
        logic [31:0] tmp;
        logic        set_c;
        logic        clr_c;
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
        switch          = sw_drv;
        o = {addr[15:2], 2'b00};
        w = en && (wen != 4'h0);
        @(posedge clk);
        if (en && wen == 4'h0) m_rdata = m_read(o);
        tn    = (w && o == 16'hE000) ? mrg(m_timer, wd, wen) : m_timer + 32'd1;
        set_c = m_cmp_en && (tn == m_cmp);
        clr_c = w && o == 16'hE008 && wen[0] && wd[1];
        m_irq = set_c || (m_irq && !clr_c);
        if (w) begin
            case (o)
                16'hF000: begin tmp = mrg({16'h0, m_led}, wd, wen); m_led = tmp[15:0]; end
                16'hF004: if (wen[0]) m_rg0 = wd[1:0];
                16'hF008: if (wen[0]) m_rg1 = wd[1:0];
                16'hF010: m_num = mrg(m_num, wd, wen);
                16'hE004: m_cmp = mrg(m_cmp, wd, wen);
                16'hE008: if (wen[0]) m_cmp_en = wd[0];
                16'hFFF0: m_scratch = mrg(m_scratch, wd, wen);
                default: ;
            endcase
        end
        m_timer    = tn;
        m_sw_prev2 = m_sw_prev1;
        m_sw_prev1 = sw_drv;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [5];
        addrs = '{32'h1FAF_F000, 32'h1FAF_E004, 32'h1FAF_FFF0, 32'h1FAF_1234, 32'h1FAF_E000};
        resetn = 1'b0;
        data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
        switch = 0;
        repeat (2) @(posedge clk);
        #1;
        if ({data_sram_rdata, led, led_rg0, led_rg1, num_data, timer_int} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdata=%h led=%h rg0=%h rg1=%h num=%h int=%b exp all 0",
                     data_sram_rdata, led, led_rg0, led_rg1, num_data, timer_int);
        end
        checks++;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            txn(1, 4'h0, addrs[i], 32'h0);
            if (data_sram_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_read[%h] got %h exp 00000000", addrs[i], data_sram_rdata);
            end
            checks++;
        end
        // four increments have happened before this read's edge
        txn(1, 4'h0, addrs[4], 32'h0);
        if (data_sram_rdata !== 32'd4) begin
            errors++;
            $display("FAIL reset_timer got %h exp 00000004", data_sram_rdata);
        end
        checks++;
        if (timer_int !== 1'b0) begin
            errors++;
            $display("FAIL reset_timer_int got %b exp 0", timer_int);
        end
        checks++;
    endtask

    task automatic test_num_merge();
        txn(1, 4'hF, 32'h1FAF_F010, 32'hAABBCCDD);
        txn(1, 4'h2, 32'h1FAF_F010, 32'h00001100);
        txn(1, 4'h0, 32'h1FAF_F010, 32'h0);
        if (data_sram_rdata !== 32'hAABB11DD) begin
            errors++;
            $display("FAIL num_merge_read got %h exp aabb11dd", data_sram_rdata);
        end
        checks++;
        if (num_data !== 32'hAABB11DD) begin
            errors++;
            $display("FAIL num_data_port got %h exp aabb11dd", num_data);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        txn(1, 4'hF, 32'h1FAF_FFF0, 32'h1234_5678);
        txn(1, 4'h0, 32'h1FAF_FFF0, 32'h0);
        if (data_sram_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_read got %h exp 12345678", data_sram_rdata);
        end
        checks++;
        txn(1, 4'hF, 32'h1FAF_FFF0, 32'hDEAD_BEEF);
        txn(0, 4'h0, 32'h1FAF_F000, 32'h0);
        if (data_sram_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rdata_hold got %h exp 12345678", data_sram_rdata);
        end
        checks++;
        txn(1, 4'h0, 32'h1FAF_FFF0, 32'h0);
        if (data_sram_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL b2b_read2 got %h exp deadbeef", data_sram_rdata);
        end
        checks++;
        txn(1, 4'h3, 32'h1FAF_F000, 32'h0000_A55A);
        txn(1, 4'h1, 32'h1FAF_F004, 32'hFFFF_FFFF);
        if (led !== 16'hA55A || led_rg0 !== 2'b11) begin
            errors++;
            $display("FAIL led_ports got led=%h rg0=%h exp a55a/3", led, led_rg0);
        end
        checks++;
    endtask

    task automatic test_timer_wrap();
        logic [31:0] exp_v [3];
        exp_v = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        txn(1, 4'hF, 32'h1FAF_E000, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            txn(1, 4'h0, 32'h1FAF_E000, 32'h0);
            if (data_sram_rdata !== exp_v[i]) begin
                errors++;
                $display("FAIL timer_wrap[%0d] got %h exp %h", i, data_sram_rdata, exp_v[i]);
            end
            checks++;
        end
    endtask

    task automatic test_irq();
        txn(1, 4'hF, 32'h1FAF_E004, 32'h20);
        txn(1, 4'h1, 32'h1FAF_E008, 32'h1);
        txn(1, 4'hF, 32'h1FAF_E000, 32'h10);
        for (int k = 1; k <= 20; k++) begin
            txn(0, 4'h0, 32'h0, 32'h0);
            if (timer_int !== (k >= 16)) begin
                errors++;
                $display("FAIL irq_rise cycle %0d got %b exp %b", k, timer_int, k >= 16);
            end
            checks++;
        end
        txn(1, 4'h1, 32'h1FAF_E008, 32'h3);
        if (timer_int !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b exp 0", timer_int);
        end
        checks++;
        // clear lands on the same edge as a match: set wins
        txn(1, 4'hF, 32'h1FAF_E000, 32'h1F);
        txn(1, 4'h1, 32'h1FAF_E008, 32'h3);
        if (timer_int !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins got %b exp 1", timer_int);
        end
        checks++;
        txn(1, 4'h0, 32'h1FAF_E008, 32'h0);
        if (data_sram_rdata !== 32'h3) begin
            errors++;
            $display("FAIL ctrl_read got %h exp 00000003", data_sram_rdata);
        end
        checks++;
        txn(1, 4'h1, 32'h1FAF_E008, 32'h2);
        if (timer_int !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear2 got %b exp 0", timer_int);
        end
        checks++;
    endtask

    task automatic test_switch();
        sw_drv = 8'h5A;
        txn(0, 4'h0, 32'h0, 32'h0);
        txn(1, 4'h0, 32'h1FAF_F020, 32'h0);
        if (data_sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL switch_early got %h exp 00000000", data_sram_rdata);
        end
        checks++;
        txn(1, 4'h0, 32'h1FAF_F020, 32'h0);
        if (data_sram_rdata !== 32'h5A) begin
            errors++;
            $display("FAIL switch_sync got %h exp 0000005a", data_sram_rdata);
        end
        checks++;
        txn(1, 4'hF, 32'h1FAF_F020, 32'hFFFF_FFFF);
        txn(1, 4'h0, 32'h1FAF_F020, 32'h0);
        if (data_sram_rdata !== 32'h5A) begin
            errors++;
            $display("FAIL switch_ro got %h exp 0000005a", data_sram_rdata);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [15:0] offs [10];
        logic [3:0]  wen;
        offs = '{16'hF000, 16'hF004, 16'hF008, 16'hF010, 16'hF020,
                 16'hE000, 16'hE004, 16'hE008, 16'hFFF0, 16'h0000};
        for (int n = 0; n < 400; n++) begin
            logic [15:0] o;
            o = offs[$urandom_range(0, 9)];
            if (o == 16'h0000) o = 16'($urandom);
            o[1:0] = 2'($urandom);
            wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if (($urandom & 15) == 0) sw_drv = 8'($urandom);
            txn(1'($urandom_range(0, 7) != 0), wen, {16'h1FAF, o}, $urandom);
            if (data_sram_rdata !== m_rdata || led !== m_led || led_rg0 !== m_rg0
                || led_rg1 !== m_rg1 || num_data !== m_num || timer_int !== m_irq) begin
                errors++;
                $display("FAIL rand[%0d] got rd=%h led=%h rg=%h/%h num=%h int=%b exp rd=%h led=%h rg=%h/%h num=%h int=%b",
                         n, data_sram_rdata, led, led_rg0, led_rg1, num_data, timer_int,
                         m_rdata, m_led, m_rg0, m_rg1, m_num, m_irq);
            end
            checks++;
        end
        txn(1, 4'h0, 32'h1FAF_E000, 32'h0);
        if (data_sram_rdata !== m_rdata) begin
            errors++;
            $display("FAIL rand_timer got %h exp %h", data_sram_rdata, m_rdata);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_num_merge();
        test_back_to_back();
        test_timer_wrap();
        test_irq();
        test_switch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
